// File: rtl/hdmi_framebuffer_reader.sv
// Frame buffer read side: prefetches 64-bit mono words and replaces the HDMI test pattern.
// Latency: hs/vs/de/data_out follow hs_in/vs_in/de_in/x_in by exactly 2 cycles.
// Backpressure: none upstream; reads are throttled by FIFO space, and a late word becomes a sticky underrun.
// Optional crosshair overlay: define FB_READER_CROSSHAIR_EN.

`ifndef HBW
`define HBW 12
`endif
`ifndef VBW
`define VBW 11
`endif

module fb_reader_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A word pushed this cycle is never visible to a pop in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);

    always_ff @(posedge clock) begin
        if (do_push && reset_n && !clear)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module hdmi_framebuffer_reader #(
    parameter int H_ACTIVE   = 1920,
    parameter int V_ACTIVE   = 1080,
    parameter int ADDR_W     = 19,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              de_in,
    input  logic [`HBW-1:0]   x_in,
    input  logic [`VBW-1:0]   y_in,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [63:0]       rd_data,
    input  logic              rd_valid,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [35:0]       data_out,
    output logic              underrun
);
    localparam int N  = H_ACTIVE * V_ACTIVE / 8;
    localparam int IW = $clog2(N+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int DW = CW + 4;

    typedef enum logic [1:0] {IDLE, FLUSH, FILL, DONE} state_t;

    state_t            state;
    logic [IW-1:0]     issued;
    logic [ADDR_W-1:0] next_addr;
    logic [CW-1:0]     outstanding;
    logic [DW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [63:0]       fifo_head;
    logic [CW:0]       occupancy;
    logic              can_issue;
    logic              rsp_accept;
    logic              rsp_drop;
    logic              flush_rsp;
    logic              pop_req;

    // Responses owed to an abandoned frame are burned off before any are kept.
    always_comb begin
        rsp_accept = 1'b0;
        rsp_drop   = 1'b0;
        if (rd_valid && state != FLUSH) begin
            if (discard != '0)
                rsp_drop = 1'b1;
            else if (outstanding != '0)
                rsp_accept = 1'b1;
        end
    end

    assign flush_rsp = rd_valid && ((discard != '0) || (outstanding != '0));
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(outstanding);
    assign can_issue = (state == FILL) && !vs_in &&
                       (occupancy < (CW+1)'(FIFO_DEPTH)) && (issued < IW'(N));
    assign pop_req   = de_in && (x_in[2:0] == 3'd0);

    fb_reader_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (state == FLUSH),
        .push     (rsp_accept),
        .push_dat (rd_data),
        .pop      (pop_req),
        .pop_dat  (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            next_addr   <= ADDR_W'(BASE_ADDR);
            issued      <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (vs_in)
                        state <= FLUSH;
                end
                FLUSH: begin
                    rd_addr     <= ADDR_W'(BASE_ADDR);
                    next_addr   <= ADDR_W'(BASE_ADDR);
                    issued      <= '0;
                    outstanding <= '0;
                    discard     <= discard + DW'(outstanding) - DW'(flush_rsp);
                    if (!vs_in)
                        state <= FILL;
                end
                FILL, DONE: begin
                    if (vs_in)
                        state <= FLUSH;
                    else if (state == FILL && issued == IW'(N))
                        state <= DONE;
                    if (can_issue) begin
                        rd_en     <= 1'b1;
                        rd_addr   <= next_addr;
                        next_addr <= next_addr + ADDR_W'(1);
                        issued    <= issued + IW'(1);
                    end
                    outstanding <= outstanding + CW'(can_issue) - CW'(rsp_accept);
                    if (rsp_drop)
                        discard <= discard - DW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [63:0] shift_word;
    logic [2:0]  sel_d1;
    logic        hs_d1;
    logic        vs_d1;
    logic        de_d1;
    logic [7:0]  pix;
`ifdef FB_READER_CROSSHAIR_EN
    logic [`HBW-1:0] x_d1;
    logic [`VBW-1:0] y_d1;
`else
    logic unused_coords;
    assign unused_coords = ^{x_in[`HBW-1:3], y_in};
`endif

    assign pix = shift_word[{sel_d1, 3'b000} +: 8];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift_word <= '0;
            sel_d1     <= '0;
            hs_d1      <= 1'b0;
            vs_d1      <= 1'b0;
            de_d1      <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            de_out     <= 1'b0;
            data_out   <= '0;
            underrun   <= 1'b0;
`ifdef FB_READER_CROSSHAIR_EN
            x_d1       <= '0;
            y_d1       <= '0;
`endif
        end else begin
            hs_d1  <= hs_in;
            vs_d1  <= vs_in;
            de_d1  <= de_in;
            sel_d1 <= x_in[2:0];
`ifdef FB_READER_CROSSHAIR_EN
            x_d1   <= x_in;
            y_d1   <= y_in;
`endif
            // An empty FIFO blanks the whole 8-pixel group; the word stays queued, so the image slips.
            if (pop_req) begin
                if (fifo_empty) begin
                    shift_word <= '0;
                    underrun   <= 1'b1;
                end else begin
                    shift_word <= fifo_head;
                end
            end
            hs_out   <= hs_d1;
            vs_out   <= vs_d1;
            de_out   <= de_d1;
            data_out <= de_d1 ? {3{pix, pix[7:4]}} : 36'd0;
`ifdef FB_READER_CROSSHAIR_EN
            if (de_d1 && (x_d1 == `HBW'(H_ACTIVE/2) || y_d1 == `VBW'(V_ACTIVE/2)))
                data_out <= 36'hFFFFFFFFF;
`endif
        end
    end
endmodule

// File: tb/tb_hdmi_framebuffer_reader.sv
// Bench for hdmi_framebuffer_reader: small 32x2 frame, in-order memory with settable latency and stalls.
`timescale 1ns/1ps
`ifndef HBW
`define HBW 12
`endif
`ifndef VBW
`define VBW 11
`endif

module tb_hdmi_framebuffer_reader;
    localparam int H     = 32;
    localparam int V     = 2;
    localparam int AW    = 19;
    localparam int BASE  = 100;
    localparam int DEPTH = 4;
    localparam int N     = H * V / 8;
    localparam int HBL   = 8;
    localparam int VSL   = 6;
    localparam int VBP   = 10;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            hs_in, vs_in, de_in;
    logic [`HBW-1:0] x_in;
    logic [`VBW-1:0] y_in;
    logic [AW-1:0]   rd_addr;
    logic            rd_en;
    logic [63:0]     rd_data;
    logic            rd_valid;
    logic            hs_out, vs_out, de_out;
    logic [35:0]     data_out;
    logic            underrun;

    always #5 clock = ~clock;

    hdmi_framebuffer_reader #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .x_in(x_in), .y_in(y_in), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
        .data_out(data_out), .underrun(underrun)
    );

    typedef struct { int addr; int due; int tag; int idx; } req_t;
    typedef struct { logic hs; logic vs; logic de; logic [35:0] dat; int x; int y; bit lit; } exp_t;

    int   checks = 0;
    int   errors = 0;
    req_t mq[$];
    int   fq[$];
    int   cyc = 0, lat = 2, stall_until = 0;
    bit   lat_rand = 0, lit_en = 0;
    int   frame_id = 0, req_idx = 0, inflight = 0, m_word = -1;
    bit   m_und = 0, seen_rst = 0;
    exp_t e1, e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [35:0] expand(input logic [7:0] p);
        return {p, p[7:4], p, p[7:4], p, p[7:4]};
    endfunction

    function automatic logic [63:0] word_of(input int idx);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(8*idx + k);
        return w;
    endfunction

    // Memory model plus reference model; each pass covers the coming rising edge.
    initial begin
        req_t       r;
        exp_t       v;
        logic [7:0] pix;
        bit         have;
        rd_valid = 1'b0;
        rd_data  = '0;
        e1 = '{default: '0};
        e2 = '{default: '0};
        forever begin
            @(negedge clock);
            if (seen_rst) begin
                check("pipe", {25'd0, hs_out, vs_out, de_out, data_out},
                              {25'd0, e2.hs, e2.vs, e2.de, e2.dat});
                check("underrun", {63'd0, underrun}, {63'd0, m_und});
                if (e2.lit && e2.de && e2.y == 0 && e2.x == 5)
                    check("lit_x5", {28'd0, data_out}, 64'h050050050);
                if (e2.lit && e2.de && e2.y == 0 && e2.x == 20)
                    check("lit_x20", {28'd0, data_out}, 64'h141141141);
            end
            cyc++;
            have = 0;
            if (mq.size() > 0 && mq[0].due <= cyc && cyc >= stall_until) begin
                r = mq.pop_front();
                have = 1;
                rd_valid = 1'b1;
                rd_data  = word_of(r.addr - BASE);
            end else begin
                rd_valid = 1'b0;
                rd_data  = 64'hDEAD_BEEF_0BAD_F00D;
            end
            v = '{default: '0};
            if (reset_n && seen_rst) begin
                v.hs = hs_in; v.vs = vs_in; v.de = de_in;
                v.x = int'(x_in); v.y = int'(y_in); v.lit = lit_en;
                if (de_in && x_in[2:0] == 3'd0) begin
                    if (fq.size() > 0) m_word = fq.pop_front();
                    else begin m_word = -1; m_und = 1; end
                end
                pix = (m_word < 0) ? 8'h00 : 8'(8*m_word + int'(x_in[2:0]));
                v.dat = de_in ? expand(pix) : 36'd0;
`ifdef FB_READER_CROSSHAIR_EN
                if (de_in && (int'(x_in) == H/2 || int'(y_in) == V/2)) v.dat = 36'hFFFFFFFFF;
`endif
                if (have && r.tag == frame_id) begin
                    fq.push_back(r.idx);
                    inflight--;
                end
            end
            if (seen_rst && rd_en === 1'b1) begin
                check("rd_addr", {45'd0, rd_addr}, 64'(BASE + req_idx));
                check("rd_count", {63'd0, req_idx < N}, 64'd1);
                mq.push_back('{addr: int'(rd_addr),
                               due: cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat),
                               tag: frame_id, idx: req_idx});
                req_idx++;
                inflight++;
                check("occupancy", {63'd0, (inflight + fq.size()) <= DEPTH}, 64'd1);
            end
            if (!reset_n) begin
                frame_id++; fq.delete(); req_idx = 0; inflight = 0;
                m_und = 0; m_word = -1; seen_rst = 1;
                e1 = '{default: '0};
                e2 = '{default: '0};
            end else begin
                if (vs_in) begin
                    frame_id++; fq.delete(); req_idx = 0; inflight = 0;
                end
                e2 = e1;
                e1 = v;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        hs_in = 0; vs_in = 0; de_in = 0; x_in = '0; y_in = '0;
    endtask

    task automatic do_frame(input int stop_y, input int stop_x, input bit stall);
        vs_in = 1; hs_in = 0; de_in = 0; x_in = '0; y_in = '0;
        repeat (VSL) tick();
        vs_in = 0;
        if (stall) stall_until = cyc + 40;
        repeat (VBP) tick();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H + HBL; x++) begin
                if (y == stop_y && x == stop_x) return;
                x_in  = `HBW'(x);
                y_in  = `VBW'(y);
                de_in = (x < H);
                hs_in = (x >= H + 2 && x < H + 5);
                tick();
            end
        end
        de_in = 0; hs_in = 0;
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        repeat (3) tick();
        check("rst_rd_en", {63'd0, rd_en}, 64'd0);
        check("rst_rd_addr", {45'd0, rd_addr}, 64'd0);
        check("rst_data", {28'd0, data_out}, 64'd0);
        check("rst_sync", {61'd0, hs_out, vs_out, de_out}, 64'd0);
        check("rst_underrun", {63'd0, underrun}, 64'd0);
        reset_n = 1;
        tick();

        lat = 2; lit_en = 1;
        do_frame(-1, -1, 0);
        check("clean_underrun", {63'd0, underrun}, 64'd0);

        lat_rand = 1;
        repeat (3) do_frame(-1, -1, 0);
        check("rand_underrun", {63'd0, underrun}, 64'd0);

        lat_rand = 0; lat = 2; lit_en = 0;
        do_frame(-1, -1, 1);
        check("stall_underrun", {63'd0, underrun}, 64'd1);
        lit_en = 1;
        do_frame(-1, -1, 0);
        check("sticky_underrun", {63'd0, underrun}, 64'd1);

        lat = 6; lit_en = 0;
        do_frame(0, 12, 0);
        lit_en = 1;
        do_frame(-1, -1, 0);

        lit_en = 0;
        do_frame(0, 20, 0);
        reset_n = 0;
        tick();
        check("mid_rst_rd_en", {63'd0, rd_en}, 64'd0);
        check("mid_rst_data", {28'd0, data_out}, 64'd0);
        check("mid_rst_sync", {61'd0, hs_out, vs_out, de_out}, 64'd0);
        check("mid_rst_underrun", {63'd0, underrun}, 64'd0);
        reset_n = 1;
        idle_inputs();
        repeat (8) tick();
        lat = 2; lit_en = 1;
        do_frame(-1, -1, 0);
        check("post_rst_underrun", {63'd0, underrun}, 64'd0);
        idle_inputs();
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
